// File: rtl/riscv_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
// Optional checksum support is controlled by IMEM_LOADER_CHECKSUM_EN.
package riscv_pkg;

    localparam int WORDS_DEFAULT  = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        CHECK,
        DONE
    } loader_state_t;

endpackage

// File: rtl/word_assembler.sv
// Packs a little-endian byte stream into 32-bit words; o_word/o_word_valid
// present the completed word in the same cycle its last byte is accepted.
module word_assembler
    import riscv_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        i_clear,
    input  logic        i_byte_en,
    input  logic [7:0]  i_byte_data,
    output logic [31:0] o_word,
    output logic        o_word_valid
);

    logic [1:0]  r_cnt;
    logic [23:0] r_low;
    logic        w_last_byte;

    assign w_last_byte = (r_cnt == 2'(BYTES_PER_WORD - 1));

    // Earlier bytes shift toward bit 0 so byte 0 ends up in [7:0].
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_low <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_byte_en) begin
            r_cnt <= w_last_byte ? 2'd0 : r_cnt + 2'd1;
            r_low <= {i_byte_data, r_low[23:8]};
        end
    end

    assign o_word       = {i_byte_data, r_low};
    assign o_word_valid = i_byte_en && w_last_byte;

endmodule

// File: rtl/imem_loader.sv
// Loads instruction memory from a byte stream, one word per five cycles.
// Define IMEM_LOADER_CHECKSUM_EN to append and verify a 32-bit word checksum.
module imem_loader
    import riscv_pkg::*;
#(
    parameter int WORDS  = WORDS_DEFAULT,
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic              cpu_stall,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    loader_state_t     r_state;
    logic [IDX_W-1:0]  r_index;
    logic [IDX_W-1:0]  r_last;
    logic              r_byte_ready;
    logic              r_mem_we;
    logic              r_busy;
    logic              r_done;
    logic [ADDR_W-1:0] r_waddr;
    logic [31:0]       r_wdata;

    logic [31:0]       w_len_ext;
    logic [IDX_W-1:0]  w_last;
    logic              w_start_ok;
    logic              w_byte_en;
    logic              w_word_valid;
    logic [31:0]       w_word;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]       r_sum;
    logic              r_error;
    assign error = r_error;
`else
    assign error = 1'b0;
`endif

    // Zero and oversize lengths both mean a full memory image.
    assign w_len_ext  = {24'd0, len};
    assign w_last     = (len == 8'd0 || w_len_ext > 32'(WORDS)) ?
                        IDX_W'(WORDS - 1) : IDX_W'(w_len_ext - 32'd1);
    assign w_start_ok = (r_state == IDLE) && start;
    assign w_byte_en  = byte_valid && r_byte_ready;

    word_assembler u_asm (
        .clock        (clock),
        .reset_n      (reset_n),
        .i_clear      (w_start_ok),
        .i_byte_en    (w_byte_en),
        .i_byte_data  (byte_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_index      <= '0;
            r_last       <= '0;
            r_byte_ready <= 1'b0;
            r_mem_we     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum        <= '0;
            r_error      <= 1'b0;
`endif
        end else begin
            r_mem_we <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state      <= RECV;
                        r_index      <= '0;
                        r_last       <= w_last;
                        r_byte_ready <= 1'b1;
                        r_busy       <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_sum        <= '0;
                        r_error      <= 1'b0;
`endif
                    end
                end
                RECV: begin
                    if (w_word_valid) begin
                        r_state      <= WRITE;
                        r_byte_ready <= 1'b0;
                        r_mem_we     <= 1'b1;
                        r_waddr      <= ADDR_W'(r_index);
                        r_wdata      <= w_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_sum        <= r_sum + w_word;
`endif
                    end
                end
                WRITE: begin
                    if (r_index == r_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_state      <= CHECK;
                        r_byte_ready <= 1'b1;
`else
                        r_state      <= DONE;
                        r_done       <= 1'b1;
`endif
                    end else begin
                        r_index      <= r_index + 1'b1;
                        r_state      <= RECV;
                        r_byte_ready <= 1'b1;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (w_word_valid) begin
                        r_error      <= (w_word != r_sum);
                        r_byte_ready <= 1'b0;
                        r_state      <= DONE;
                        r_done       <= 1'b1;
                    end
                end
`endif
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state      <= IDLE;
                    r_byte_ready <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign byte_ready = r_byte_ready;
    assign mem_waddr  = r_waddr;
    assign mem_wdata  = r_wdata;
    assign mem_we     = r_mem_we;
    assign cpu_stall  = r_busy;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
